// File: rtl/nios_fprint_processor0_0_cpu0_mul_seq.sv
// Issue/retire sequencer around the CPU's two-register 32x32 multiplier cell.
// Drives the cell's operands and stage enables, and returns the selected result word with its tag.
module nios_fprint_processor0_0_cpu0_mul_seq #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic [31:0]      mul_src1,
  output logic [31:0]      mul_src2,
  output logic             mul_src1_signed,
  output logic             mul_src2_signed,
  output logic             mul_m_en,
  output logic             mul_a_en,
  input  logic [63:0]      mul_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic [1:0]       inflight,
  output logic [31:0]      ops_done
);

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULXSS = 2'd1,
    OP_MULXSU = 2'd2,
    OP_MULXUU = 2'd3
  } mul_op_e;

  typedef struct packed {
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
  } stage_t;

  logic        v_m, v_a;
  stage_t      st_m, st_a;
  logic [31:0] ops_cnt;
  logic        a_en, m_en, accept, retire;

  // Stage enables ripple backwards from the consumer so a full pipe still
  // advances in lockstep when res_ready is high.
  assign a_en   = ~v_a | res_ready;
  assign m_en   = ~v_m | a_en;
  assign accept = req_valid & req_ready;
  assign retire = res_valid & res_ready;

  assign req_ready = ~reset & m_en & ~flush;
  assign mul_m_en  = ~reset & m_en;
  assign mul_a_en  = ~reset & a_en;

  assign mul_src1        = req_a;
  assign mul_src2        = req_b;
  assign mul_src1_signed = (req_op == OP_MULXSS) | (req_op == OP_MULXSU);
  assign mul_src2_signed = (req_op == OP_MULXSS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_m  <= 1'b0;
      v_a  <= 1'b0;
      st_m <= '0;
      st_a <= '0;
    end else if (flush) begin
      v_m <= 1'b0;
      v_a <= 1'b0;
    end else begin
      if (a_en) begin
        v_a  <= v_m;
        st_a <= st_m;
      end
      if (m_en) begin
        v_m <= accept;
        if (accept) st_m <= '{op: req_op, tag: req_tag};
      end
    end
  end

  // A result retiring on a flush edge was already delivered, so it still counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       ops_cnt <= '0;
    else if (retire) ops_cnt <= ops_cnt + 32'd1;
  end

  always_comb begin
    res_valid = v_a & ~reset;
    res_data  = '0;
    res_tag   = '0;
    if (res_valid) begin
      res_tag  = st_a.tag;
      res_data = (st_a.op == OP_MUL) ? mul_result[31:0] : mul_result[63:32];
    end
  end

  assign inflight = reset ? 2'd0 : ({1'b0, v_m} + {1'b0, v_a});
  assign ops_done = ops_cnt;

endmodule

// File: tb/tb_nios_fprint_processor0_0_cpu0_mul_seq.sv
// Directed bench for the multiplier sequencer; includes a behavioural two-register multiplier cell.
module tb_nios_fprint_processor0_0_cpu0_mul_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [4:0]  req_tag;
  logic        flush;
  logic [31:0] mul_src1, mul_src2;
  logic        mul_src1_signed, mul_src2_signed, mul_m_en, mul_a_en;
  logic [63:0] mul_result;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_tag;
  logic [1:0]  inflight;
  logic [31:0] ops_done;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_ops = 0;

  always #5 clk = ~clk;

  nios_fprint_processor0_0_cpu0_mul_seq #(.TAG_W(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .flush(flush),
    .mul_src1(mul_src1), .mul_src2(mul_src2),
    .mul_src1_signed(mul_src1_signed), .mul_src2_signed(mul_src2_signed),
    .mul_m_en(mul_m_en), .mul_a_en(mul_a_en), .mul_result(mul_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .inflight(inflight), .ops_done(ops_done)
  );

  // Multiplier cell: input register (ena0) then output register (ena1)
  logic [31:0]        c_a = '0, c_b = '0;
  logic               c_sa = 1'b0, c_sb = 1'b0;
  logic signed [65:0] c_prod;
  assign c_prod = $signed({c_sa & c_a[31], c_a}) * $signed({c_sb & c_b[31], c_b});
  always @(posedge clk) begin
    if (mul_m_en) begin
      c_a <= mul_src1; c_b <= mul_src2; c_sa <= mul_src1_signed; c_sb <= mul_src2_signed;
    end
    if (mul_a_en) mul_result <= c_prod[63:0];
  end

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 0; req_op = 0; req_a = 0; req_b = 0; req_tag = 0;
    flush = 0; res_ready = 1'b1; mul_result = '0;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
    checks++; if (mul_m_en !== 1'b0 || mul_a_en !== 1'b0) begin errors++; $display("FAIL reset_enables got %b%b want 00", mul_m_en, mul_a_en); end
    checks++; if (res_valid !== 1'b0 || res_data !== 32'h0 || res_tag !== 5'h0) begin errors++; $display("FAIL reset_res got v=%b d=%h t=%h want 0", res_valid, res_data, res_tag); end
    checks++; if (inflight !== 2'd0 || ops_done !== 32'h0) begin errors++; $display("FAIL reset_counts got inflight=%0d ops=%0d want 0", inflight, ops_done); end
    reset = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", req_ready); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk); res_ready = 1'b1; drive(2'd0, 32'd3, 32'd5, 5'd1); #1;
    checks++; if (req_ready !== 1'b1 || mul_m_en !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b/%b want 1/1", req_ready, mul_m_en); end
    checks++; if (mul_src1 !== 32'd3 || mul_src2 !== 32'd5) begin errors++; $display("FAIL b2b_src got %h/%h want 3/5", mul_src1, mul_src2); end
    checks++; if (mul_src1_signed !== 1'b0 || mul_src2_signed !== 1'b0) begin errors++; $display("FAIL mul_sign got %b%b want 00", mul_src1_signed, mul_src2_signed); end
    @(negedge clk); drive(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2); #1;
    checks++; if (req_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL b2b_second got ready=%b rv=%b want 1/0", req_ready, res_valid); end
    @(negedge clk); req_valid = 1'b0;
    checks++; if (res_valid !== 1'b1 || res_data !== 32'h0000_000F || res_tag !== 5'd1) begin errors++; $display("FAIL b2b_res1 got v=%b d=%h t=%0d want 1/0000000f/1", res_valid, res_data, res_tag); end
    checks++; if (inflight !== 2'd2) begin errors++; $display("FAIL b2b_inflight got %0d want 2", inflight); end
    @(negedge clk);
    checks++; if (res_valid !== 1'b1 || res_data !== 32'hFFFF_FFFE || res_tag !== 5'd2) begin errors++; $display("FAIL b2b_res2 got v=%b d=%h t=%0d want 1/fffffffe/2", res_valid, res_data, res_tag); end
    @(negedge clk); exp_ops = exp_ops + 2;
    checks++; if (res_valid !== 1'b0 || res_data !== 32'h0 || ops_done !== exp_ops) begin errors++; $display("FAIL b2b_done got v=%b d=%h ops=%0d want 0/0/%0d", res_valid, res_data, ops_done, exp_ops); end
  endtask

  task automatic test_signedness;
    logic [1:0]  ops [3];
    logic [31:0] hi [3];
    logic [1:0]  sg [3];
    ops[0] = 2'd1; hi[0] = 32'hFFFF_FFFF; sg[0] = 2'b11;
    ops[1] = 2'd2; hi[1] = 32'hFFFF_FFFF; sg[1] = 2'b10;
    ops[2] = 2'd3; hi[2] = 32'h0000_0001; sg[2] = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(ops[i], 32'hFFFF_FFFF, 32'h0000_0002, 5'(20 + i)); #1;
      checks++; if ({mul_src1_signed, mul_src2_signed} !== sg[i]) begin errors++; $display("FAIL sign_op%0d got %b%b want %b", ops[i], mul_src1_signed, mul_src2_signed, sg[i]); end
      @(negedge clk); req_valid = 1'b0;
      @(negedge clk);
      checks++; if (res_valid !== 1'b1 || res_data !== hi[i] || res_tag !== 5'(20 + i)) begin errors++; $display("FAIL sign_res_op%0d got v=%b d=%h t=%0d want 1/%h/%0d", ops[i], res_valid, res_data, res_tag, hi[i], 20 + i); end
      exp_ops = exp_ops + 1;
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); drive(2'd0, 32'(i + 1), 32'd10, 5'(11 + i));
      @(negedge clk); req_valid = 1'b0;
      @(negedge clk);
      checks++; if (res_data !== 32'((i + 1) * 10)) begin errors++; $display("FAIL rmid_pre%0d got %h want %h", i, res_data, (i + 1) * 10); end
      exp_ops = exp_ops + 1;
    end
    @(negedge clk); res_ready = 1'b0; drive(2'd0, 32'd2, 32'd2, 5'd13);
    @(negedge clk); drive(2'd0, 32'd3, 32'd3, 5'd14);
    @(negedge clk); drive(2'd0, 32'd4, 32'd4, 5'd15); #1;
    checks++; if (inflight !== 2'd2 || ops_done !== 32'd7 || req_ready !== 1'b0) begin errors++; $display("FAIL rmid_stall got inflight=%0d ops=%0d ready=%b want 2/7/0", inflight, ops_done, req_ready); end
    #2 reset = 1'b1; #1;
    checks++; if (req_ready !== 1'b0 || mul_m_en !== 1'b0 || mul_a_en !== 1'b0) begin errors++; $display("FAIL rmid_ctrl got %b%b%b want 000", req_ready, mul_m_en, mul_a_en); end
    checks++; if (res_valid !== 1'b0 || res_data !== 32'h0 || res_tag !== 5'h0) begin errors++; $display("FAIL rmid_res got v=%b d=%h t=%h want 0", res_valid, res_data, res_tag); end
    checks++; if (inflight !== 2'd0 || ops_done !== 32'd0) begin errors++; $display("FAIL rmid_counts got inflight=%0d ops=%0d want 0/0", inflight, ops_done); end
    exp_ops = 0;
    @(negedge clk); reset = 1'b0; req_valid = 1'b0; res_ready = 1'b1; #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmid_reopen got %b want 1", req_ready); end
    drive(2'd0, 32'd7, 32'd9, 5'd10);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    checks++; if (res_valid !== 1'b1 || res_data !== 32'd63 || res_tag !== 5'd10) begin errors++; $display("FAIL rmid_after got v=%b d=%0d t=%0d want 1/63/10", res_valid, res_data, res_tag); end
    exp_ops = exp_ops + 1;
  endtask

  task automatic test_backpressure;
    @(negedge clk); res_ready = 1'b0; drive(2'd0, 32'd2, 32'd3, 5'd3); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_first got %b want 1", req_ready); end
    @(negedge clk); drive(2'd0, 32'd4, 32'd5, 5'd4); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_second got %b want 1", req_ready); end
    @(negedge clk); drive(2'd0, 32'd6, 32'd7, 5'd5); #1;
    checks++; if (req_ready !== 1'b0 || inflight !== 2'd2) begin errors++; $display("FAIL bp_full got ready=%b inflight=%0d want 0/2", req_ready, inflight); end
    checks++; if (res_valid !== 1'b1 || res_data !== 32'd6 || res_tag !== 5'd3) begin errors++; $display("FAIL bp_head got v=%b d=%0d t=%0d want 1/6/3", res_valid, res_data, res_tag); end
    @(negedge clk); #1;
    checks++; if (inflight !== 2'd2 || res_data !== 32'd6 || mul_m_en !== 1'b0 || mul_a_en !== 1'b0) begin errors++; $display("FAIL bp_hold got inflight=%0d d=%0d en=%b%b want 2/6/00", inflight, res_data, mul_m_en, mul_a_en); end
    res_ready = 1'b1; #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b want 1", req_ready); end
    @(negedge clk); req_valid = 1'b0;
    checks++; if (res_valid !== 1'b1 || res_data !== 32'd20 || res_tag !== 5'd4) begin errors++; $display("FAIL bp_res2 got v=%b d=%0d t=%0d want 1/20/4", res_valid, res_data, res_tag); end
    @(negedge clk);
    checks++; if (res_valid !== 1'b1 || res_data !== 32'd42 || res_tag !== 5'd5) begin errors++; $display("FAIL bp_res3 got v=%b d=%0d t=%0d want 1/42/5", res_valid, res_data, res_tag); end
    @(negedge clk); exp_ops = exp_ops + 3;
    checks++; if (res_valid !== 1'b0 || inflight !== 2'd0 || ops_done !== exp_ops) begin errors++; $display("FAIL bp_drain got v=%b inflight=%0d ops=%0d want 0/0/%0d", res_valid, inflight, ops_done, exp_ops); end
  endtask

  task automatic test_flush;
    @(negedge clk); res_ready = 1'b0; drive(2'd0, 32'd1, 32'd2, 5'd6);
    @(negedge clk); drive(2'd0, 32'd3, 32'd4, 5'd7);
    @(negedge clk); drive(2'd0, 32'd5, 32'd6, 5'd8); flush = 1'b1; #1;
    checks++; if (req_ready !== 1'b0 || inflight !== 2'd2) begin errors++; $display("FAIL flush_pre got ready=%b inflight=%0d want 0/2", req_ready, inflight); end
    @(negedge clk); flush = 1'b0; req_valid = 1'b0;
    checks++; if (inflight !== 2'd0 || res_valid !== 1'b0 || res_data !== 32'h0) begin errors++; $display("FAIL flush_clear got inflight=%0d v=%b d=%h want 0/0/0", inflight, res_valid, res_data); end
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost%0d got v=%b t=%0d want 0", i, res_valid, res_tag); end
    end
    checks++; if (ops_done !== exp_ops) begin errors++; $display("FAIL flush_ops got %0d want %0d", ops_done, exp_ops); end
    drive(2'd0, 32'd1, 32'd1, 5'd9);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    checks++; if (res_valid !== 1'b1 || res_tag !== 5'd9) begin errors++; $display("FAIL flush_ret_pre got v=%b t=%0d want 1/9", res_valid, res_tag); end
    flush = 1'b1;
    @(negedge clk); flush = 1'b0; exp_ops = exp_ops + 1;
    checks++; if (res_valid !== 1'b0 || ops_done !== exp_ops) begin errors++; $display("FAIL flush_ret got v=%b ops=%0d want 0/%0d", res_valid, ops_done, exp_ops); end
  endtask

  task automatic test_wrap;
    @(negedge clk); res_ready = 1'b0; drive(2'd0, 32'd2, 32'd2, 5'd12);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    checks++; if (res_valid !== 1'b1 || res_data !== 32'd4) begin errors++; $display("FAIL wrap_pre got v=%b d=%0d want 1/4", res_valid, res_data); end
    force dut.ops_cnt = 32'hFFFF_FFFF;
    #1 release dut.ops_cnt;
    res_ready = 1'b1;
    @(negedge clk);
    checks++; if (ops_done !== 32'h0 || res_valid !== 1'b0) begin errors++; $display("FAIL wrap got ops=%h v=%b want 00000000/0", ops_done, res_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_signedness();
    test_reset_mid();
    test_backpressure();
    test_flush();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nios_fprint_processor0_0_cpu0_mul_seq.md
# nios_fprint_processor0_0_cpu0_mul_seq

Issue/retire sequencer placed directly upstream and downstream of the CPU's 32x32 hardware multiplier cell. It accepts multiply requests on a valid/ready handshake and drives the cell's operands, signedness controls and two stage enables. It tracks the cell's two-register pipeline (input register, then output register) and returns the selected 32-bit result word with a passthrough tag on a second valid/ready handshake. It supports flush and backpressure.

## Interface
- TAG_W, 5, width of the destination tag carried alongside each operation
- clk  in  1  sole clock; every register is rising-edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted on an edge where req_valid && req_ready
- req_op  in  2  0=MUL (low word), 1=MULXSS, 2=MULXSU, 3=MULXUU (high word)
- req_a, req_b  in  32  operands
- req_tag  in  TAG_W  tag returned with the result
- flush  in  1  cancels all in-flight operations
- mul_src1, mul_src2  out  32  to cell dataa/datab; equal to req_a/req_b (combinational)
- mul_src1_signed, mul_src2_signed  out  1  to cell signa/signb
- mul_m_en  out  1  cell input-register enable (ena0)
- mul_a_en  out  1  cell output-register enable (ena1)
- mul_result  in  64  registered product from the cell
- res_valid  out  1  result present
- res_ready  in  1  consumer accepts
- res_data  out  32  selected result word
- res_tag  out  TAG_W  tag of the returned operation
- inflight  out  2  count of valid stages (0..2)
- ops_done  out  32  count of completed operations

## Operation
- Two valid bits track the cell: v_m for the cell input register and v_a for the cell output register. Shadow registers op_m/tag_m and op_a/tag_a run alongside.
- Stage enables:
  - a_en = ~v_a | res_ready
  - m_en = ~v_m | a_en
  - mul_a_en = a_en, mul_m_en = m_en
  - req_ready = m_en & ~flush
- Accept: on an edge with req_valid & req_ready, set v_m=1 and capture req_op and req_tag.
- If m_en is high and there is no accept, set v_m=0. The cell may load don't-care operands; they are never returned.
- A advance: on an edge with a_en, set v_a=v_m and copy op_m/tag_m into op_a/tag_a.
- Stall: with res_valid=1 and res_ready=0, both stages hold and req_ready=0 when v_m=1. The cell registers hold because their enables are low.
- Signedness, decoded from req_op:
  - MUL: 0/0
  - MULXSS: 1/1
  - MULXSU: 1/0
  - MULXUU: 0/0
- Result select:
  - op_a==MUL: res_data = mul_result[31:0]
  - otherwise: res_data = mul_result[63:32]
  - res_data = 0 and res_tag = 0 whenever res_valid=0.
- res_valid = v_a, inflight = v_m + v_a.
- ops_done increments by 1 on each edge with res_valid & res_ready. It wraps from 0xFFFFFFFF to 0. Flush does not clear it.
- Flush:
  - On an edge with flush=1, v_m and v_a are cleared.
  - No request is accepted on that edge (req_ready=0 while flush=1).
  - A result handshaking on that same edge still counts in ops_done.
- Reset:
  - v_m, v_a, op/tag shadows and ops_done are cleared to 0.
  - While reset=1: req_ready, mul_m_en and mul_a_en are forced to 0; res_valid=0, res_data=0, res_tag=0, inflight=0.
  - A reset mid-operation discards all in-flight operations.

## Timing
- Latency: a request accepted at edge T returns with res_valid=1 after edge T+1, provided a_en=1 at T+1. This is 2 edges accept-to-result.
- Throughput: one operation per cycle with res_ready held high; req_ready stays 1.
- Backpressure is absorbed in 2 entries: with res_ready=0, the first request fills A, the second fills M, and req_ready then falls combinationally.
- res_ready returning high reopens req_ready in the same cycle; the pipeline advances in lockstep with no bubble.
- Output side:
  - res_data, res_tag and res_valid derive only from registered state and the registered mul_result; there is no path from req_* to them.
  - req_ready depends combinationally on res_ready and flush.

## Test plan
- Unsigned back-to-back: MUL 3*5, then MULXUU 0xFFFFFFFF*0xFFFFFFFF, res_ready=1 → res_data 0x0000000F, then 0xFFFFFFFE on consecutive cycles, 2 edges after each accept; tags match.
- Signedness: MULXSS 0xFFFFFFFF*0x00000002 → 0xFFFFFFFF; MULXSU same operands → 0xFFFFFFFF; MULXUU → 0x00000001.
- Backpressure: res_ready=0 with 3 back-to-back requests → first two accepted, req_ready=0 with inflight=2, third held. Releasing res_ready returns all three in order with no loss or duplication.
- Flush with inflight=2 and a simultaneous req_valid → next cycle inflight=0, res_valid=0, and the flushed request is never returned.
- Reset asserted mid-stall (inflight=2, ops_done=7) → all outputs 0 immediately. After deassertion, req_ready=1 and the next op returns normally.
- Counter wrap: preload via 2^32-1 completions (force) → next handshake gives ops_done=0.
